// File: rtl/eth_parser_multi_if.sv
// Header-word / result-head bundle between the packet front end and the Ethernet header parser.
interface eth_parser_multi_if #(
    parameter int unsigned DATA_WIDTH       = 256,
    parameter int unsigned NUM_QUEUES_WIDTH = 3
);
    logic [DATA_WIDTH-1:0]       tdata;
    logic                        word_IP_DST_HI;
    logic                        eth_parser_rd_info;
    logic                        eth_parser_info_vld;
    logic                        is_for_us;
    logic                        is_arp_pkt;
    logic                        is_ip_pkt;
    logic                        is_broadcast;
    logic                        is_multicast;
    logic                        is_vlan;
    logic [11:0]                 vlan_id;
    logic [NUM_QUEUES_WIDTH-1:0] mac_dst_port_num;

    modport master (
        output tdata, word_IP_DST_HI, eth_parser_rd_info,
        input  eth_parser_info_vld, is_for_us, is_arp_pkt, is_ip_pkt, is_broadcast,
               is_multicast, is_vlan, vlan_id, mac_dst_port_num
    );

    modport slave (
        input  tdata, word_IP_DST_HI, eth_parser_rd_info,
        output eth_parser_info_vld, is_for_us, is_arp_pkt, is_ip_pkt, is_broadcast,
               is_multicast, is_vlan, vlan_id, mac_dst_port_num
    );
endinterface

// File: rtl/eth_parser_multi.sv
// Ethernet header parser: captures dst MAC / ethertype (one optional 802.1Q tag), searches the
// port MAC table one entry per cycle and queues one classification result per accepted header.
module eth_parser_multi #(
    parameter int unsigned C_S_AXIS_DATA_WIDTH = 256,
    parameter int unsigned NUM_MAC_PORTS       = 4,
    parameter int unsigned NUM_QUEUES_WIDTH    = $clog2(2 * NUM_MAC_PORTS),
    parameter int unsigned FIFO_DEPTH_BITS     = 2,
    parameter bit          ACCEPT_MCAST        = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [48*NUM_MAC_PORTS-1:0]  mac_table,
    output logic [31:0]                  hdr_drop_count,
    eth_parser_multi_if.slave            bus
);
    localparam int unsigned W     = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int unsigned IW    = $clog2(NUM_MAC_PORTS) + 1;

    typedef logic [FIFO_DEPTH_BITS-1:0] ptr_t;
    typedef logic [FIFO_DEPTH_BITS:0]   cnt_t;
    typedef logic [IW-1:0]              idx_t;

    typedef struct packed {
        logic [47:0] dst;
        logic [15:0] etype_outer;
        logic [11:0] vid;
        logic [15:0] etype_inner;
    } hdr_t;

    typedef struct packed {
        logic                        for_us;
        logic                        arp;
        logic                        ip;
        logic                        bcast;
        logic                        mcast;
        logic                        vlan;
        logic [11:0]                 vid;
        logic [NUM_QUEUES_WIDTH-1:0] port;
    } res_t;

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_WRITE} state_t;

    // Bytes of the first word that the parser never looks at (src MAC, PCP/DEI, payload).
    logic unused_tdata;
    assign unused_tdata = ^{bus.tdata[W-49 -: 48], bus.tdata[W-113 -: 4], bus.tdata[W-145:0]};

    hdr_t   cap_q;
    logic   push_q;
    hdr_t   hfifo_q [DEPTH];
    ptr_t   hwr_q, hrd_q;
    cnt_t   hcnt_q;
    logic [31:0] drop_q;
    res_t   rfifo_q [DEPTH];
    ptr_t   rwr_q, rrd_q;
    cnt_t   rcnt_q;
    state_t state_q;
    idx_t   idx_q;
    logic   found_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q  <= '0;
            push_q <= 1'b0;
        end else begin
            push_q <= bus.word_IP_DST_HI;
            if (bus.word_IP_DST_HI) begin
                cap_q <= '{dst:         bus.tdata[W-1   -: 48],
                           etype_outer: bus.tdata[W-97  -: 16],
                           vid:         bus.tdata[W-117 -: 12],
                           etype_inner: bus.tdata[W-129 -: 16]};
            end
        end
    end

    // Header FIFO: fullness is judged before the same-cycle pop, so a push into a full FIFO drops.
    logic hfull, hpush_ok, hpop;
    assign hfull    = (hcnt_q == cnt_t'(DEPTH));
    assign hpush_ok = push_q && !hfull;
    assign hpop     = (state_q == S_WRITE);

    always_ff @(posedge clk) begin
        if (hpush_ok) hfifo_q[hwr_q] <= cap_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hwr_q  <= '0;
            hrd_q  <= '0;
            hcnt_q <= '0;
            drop_q <= '0;
        end else begin
            if (hpush_ok) hwr_q <= hwr_q + ptr_t'(1);
            if (hpop)     hrd_q <= hrd_q + ptr_t'(1);
            if (hpush_ok && !hpop)      hcnt_q <= hcnt_q + cnt_t'(1);
            else if (!hpush_ok && hpop) hcnt_q <= hcnt_q - cnt_t'(1);
            if (push_q && hfull && (drop_q != '1)) drop_q <= drop_q + 32'd1;
        end
    end

    assign hdr_drop_count = drop_q;

    hdr_t        hh;
    logic        h_bcast, h_mcast, h_vlan;
    logic [15:0] h_etype;
    logic [47:0] tbl_ent;

    assign hh      = hfifo_q[hrd_q];
    assign h_bcast = &hh.dst;
    assign h_mcast = hh.dst[40] && !h_bcast;
    assign h_vlan  = (hh.etype_outer == 16'h8100);
    assign h_etype = h_vlan ? hh.etype_inner : hh.etype_outer;

    always_comb begin
        tbl_ent = '0;
        for (int unsigned i = 0; i < NUM_MAC_PORTS; i++) begin
            if (idx_q == idx_t'(i)) tbl_ent = mac_table[48*i +: 48];
        end
    end

    logic rfull, rvld, rpush, rpop;
    assign rfull = (rcnt_q == cnt_t'(DEPTH));
    assign rvld  = (rcnt_q != '0);
    assign rpush = (state_q == S_WRITE);
    assign rpop  = bus.eth_parser_rd_info && rvld;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            found_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if ((hcnt_q != '0) && !rfull) begin
                        state_q <= S_SEARCH;
                        idx_q   <= '0;
                        found_q <= 1'b0;
                    end
                end
                S_SEARCH: begin
                    if (h_bcast || h_mcast) begin
                        state_q <= S_WRITE;
                        found_q <= 1'b1;
                        idx_q   <= '0;
                    end else if (hh.dst == tbl_ent) begin
                        state_q <= S_WRITE;
                        found_q <= 1'b1;
                    end else if (idx_q == idx_t'(NUM_MAC_PORTS - 1)) begin
                        state_q <= S_WRITE;
                        found_q <= 1'b0;
                    end else begin
                        idx_q <= idx_q + idx_t'(1);
                    end
                end
                S_WRITE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // found_q is also set for group addresses, so for_us re-derives the multicast policy here.
    res_t wres;
    always_comb begin
        wres        = '0;
        wres.bcast  = h_bcast;
        wres.mcast  = h_mcast;
        wres.vlan   = h_vlan;
        wres.vid    = h_vlan ? hh.vid : 12'h000;
        wres.arp    = (h_etype == 16'h0806);
        wres.ip     = (h_etype == 16'h0800);
        wres.for_us = h_bcast || (h_mcast && ACCEPT_MCAST) || (found_q && !h_bcast && !h_mcast);
        wres.port   = found_q ? NUM_QUEUES_WIDTH'({idx_q, 1'b0}) : '0;
    end

    always_ff @(posedge clk) begin
        if (rpush && !rfull) rfifo_q[rwr_q] <= wres;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rwr_q  <= '0;
            rrd_q  <= '0;
            rcnt_q <= '0;
        end else begin
            if (rpush && !rfull) rwr_q <= rwr_q + ptr_t'(1);
            if (rpop)            rrd_q <= rrd_q + ptr_t'(1);
            if ((rpush && !rfull) && !rpop)      rcnt_q <= rcnt_q + cnt_t'(1);
            else if (!(rpush && !rfull) && rpop) rcnt_q <= rcnt_q - cnt_t'(1);
        end
    end

    res_t rh;
    assign rh = rvld ? rfifo_q[rrd_q] : '0;

    assign bus.eth_parser_info_vld = rvld;
    assign bus.is_for_us           = rh.for_us;
    assign bus.is_arp_pkt          = rh.arp;
    assign bus.is_ip_pkt           = rh.ip;
    assign bus.is_broadcast        = rh.bcast;
    assign bus.is_multicast        = rh.mcast;
    assign bus.is_vlan             = rh.vlan;
    assign bus.vlan_id             = rh.vid;
    assign bus.mac_dst_port_num    = rh.port;
endmodule

// File: tb/tb_eth_parser_multi.sv
// Randomized bench for eth_parser_multi: two instances (multicast accepted / rejected) share stimulus
// and are compared against a header-rules reference model, including latency, overflow and reset.
module tb_eth_parser_multi;
    localparam int DW  = 256;
    localparam int N   = 4;
    localparam int NQW = 3;

    typedef struct {
        bit         for_us;
        bit         arp;
        bit         ip;
        bit         bcast;
        bit         mcast;
        bit         vlan;
        logic [11:0] vid;
        logic [2:0] port;
        int         lat;
    } exp_t;

    logic clk;
    logic reset;
    logic [DW-1:0] tdata;
    logic word;
    logic rd;
    logic [48*N-1:0] mac_table;
    logic [31:0] drop_a, drop_b;
    logic [47:0] tbl [N];

    int n_chk  = 0;
    int n_fail = 0;
    int obs_lat;
    logic [2:0] obs_port;

    eth_parser_multi_if #(.DATA_WIDTH(DW), .NUM_QUEUES_WIDTH(NQW)) bus_a ();
    eth_parser_multi_if #(.DATA_WIDTH(DW), .NUM_QUEUES_WIDTH(NQW)) bus_b ();

    assign bus_a.tdata              = tdata;
    assign bus_a.word_IP_DST_HI     = word;
    assign bus_a.eth_parser_rd_info = rd;
    assign bus_b.tdata              = tdata;
    assign bus_b.word_IP_DST_HI     = word;
    assign bus_b.eth_parser_rd_info = rd;

    eth_parser_multi #(.C_S_AXIS_DATA_WIDTH(DW), .NUM_MAC_PORTS(N), .NUM_QUEUES_WIDTH(NQW),
                       .FIFO_DEPTH_BITS(2), .ACCEPT_MCAST(1'b1))
        u_dut_a (.clk(clk), .reset(reset), .mac_table(mac_table), .hdr_drop_count(drop_a), .bus(bus_a));

    eth_parser_multi #(.C_S_AXIS_DATA_WIDTH(DW), .NUM_MAC_PORTS(N), .NUM_QUEUES_WIDTH(NQW),
                       .FIFO_DEPTH_BITS(2), .ACCEPT_MCAST(1'b0))
        u_dut_b (.clk(clk), .reset(reset), .mac_table(mac_table), .hdr_drop_count(drop_b), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_table();
        for (int i = 0; i < N; i++) mac_table[48*i +: 48] = tbl[i];
    endtask

    // Reference classification straight from the header rules.
    function automatic exp_t model(input logic [47:0] dst, input logic [15:0] eo, input logic [15:0] tci,
                                   input logic [15:0] ei, input bit acc);
        exp_t e;
        int k = -1;
        logic [15:0] eff;
        e.bcast = (dst == 48'hFFFF_FFFF_FFFF);
        e.mcast = dst[40] && !e.bcast;
        for (int i = N - 1; i >= 0; i--) if (tbl[i] == dst) k = i;
        e.vlan  = (eo == 16'h8100);
        eff     = e.vlan ? ei : eo;
        e.arp   = (eff == 16'h0806);
        e.ip    = (eff == 16'h0800);
        e.vid   = e.vlan ? tci[11:0] : 12'h000;
        e.for_us = e.bcast || (e.mcast && acc) || (!e.bcast && !e.mcast && k >= 0);
        e.port  = (!e.bcast && !e.mcast && k >= 0) ? 3'(2 * k) : 3'd0;
        e.lat   = (e.bcast || e.mcast) ? 5 : ((k >= 0) ? 5 + k : 4 + N);
        return e;
    endfunction

    function automatic logic [DW-1:0] make_word(input logic [47:0] dst, input logic [15:0] eo,
                                                input logic [15:0] tci, input logic [15:0] ei);
        logic [DW-1:0] d;
        for (int b = 0; b < DW / 8; b++) d[DW-1-8*b -: 8] = 8'($urandom);
        d[DW-1-8*0  -: 48] = dst;
        d[DW-1-8*12 -: 16] = eo;
        d[DW-1-8*14 -: 16] = tci;
        d[DW-1-8*16 -: 16] = ei;
        return d;
    endfunction

    task automatic gen_pkt(output logic [47:0] dst, output logic [15:0] eo, output logic [15:0] tci,
                           output logic [15:0] ei);
        logic [63:0] r64;
        int sel;
        r64 = {$urandom(), $urandom()};
        sel = $urandom_range(0, 5);
        case (sel)
            0: dst = 48'hFFFF_FFFF_FFFF;
            1: begin
                dst = r64[47:0];
                dst[40] = 1'b1;
                if (dst == 48'hFFFF_FFFF_FFFF) dst[0] = 1'b0;
            end
            2: begin
                dst = r64[47:0];
                dst[47:40] = 8'h06;
            end
            default: dst = tbl[$urandom_range(0, N - 1)];
        endcase
        tci = 16'($urandom);
        ei  = 16'($urandom);
        case ($urandom_range(0, 3))
            0: eo = 16'h0800;
            1: eo = 16'h0806;
            2: begin
                eo = 16'h8100;
                if ($urandom_range(0, 2) == 0) ei = 16'h0800;
                else if ($urandom_range(0, 1) == 0) ei = 16'h0806;
            end
            default: eo = 16'($urandom);
        endcase
    endtask

    task automatic check_heads(input string tag, input exp_t ea, input exp_t eb);
        chk({tag, ".vld_a"},   bus_a.eth_parser_info_vld, 1);
        chk({tag, ".vld_b"},   bus_b.eth_parser_info_vld, 1);
        chk({tag, ".for_us"},  bus_a.is_for_us,        ea.for_us);
        chk({tag, ".for_usB"}, bus_b.is_for_us,        eb.for_us);
        chk({tag, ".arp"},     bus_a.is_arp_pkt,       ea.arp);
        chk({tag, ".ip"},      bus_a.is_ip_pkt,        ea.ip);
        chk({tag, ".bcast"},   bus_a.is_broadcast,     ea.bcast);
        chk({tag, ".mcast"},   bus_a.is_multicast,     ea.mcast);
        chk({tag, ".vlan"},    bus_a.is_vlan,          ea.vlan);
        chk({tag, ".vid"},     bus_a.vlan_id,          ea.vid);
        chk({tag, ".port"},    bus_a.mac_dst_port_num, ea.port);
        chk({tag, ".portB"},   bus_b.mac_dst_port_num, eb.port);
    endtask

    // Sends one header into an idle parser, measures latency, checks and pops the result.
    task automatic run_one(input string tag, input logic [47:0] dst, input logic [15:0] eo,
                           input logic [15:0] tci, input logic [15:0] ei);
        exp_t ea, eb;
        int lat;
        ea = model(dst, eo, tci, ei, 1'b1);
        eb = model(dst, eo, tci, ei, 1'b0);
        tdata = make_word(dst, eo, tci, ei);
        word  = 1'b1;
        lat   = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            word = 1'b0;
            if (bus_a.eth_parser_info_vld) break;
        end
        obs_lat  = lat;
        obs_port = bus_a.mac_dst_port_num;
        chk({tag, ".lat"}, 64'(lat), 64'(ea.lat));
        check_heads(tag, ea, eb);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk({tag, ".vld_after_pop"}, bus_a.eth_parser_info_vld, 0);
    endtask

    initial begin
        logic [47:0] dst;
        logic [15:0] eo, tci, ei;
        exp_t qa[$], qb[$];
        int waited;

        for (int i = 0; i < N; i++) tbl[i] = 48'h0200_0000_0000 | 48'(i);
        apply_table();
        tdata = '0;
        word  = 1'b0;
        rd    = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("reset.vld",   bus_a.eth_parser_info_vld, 0);
        chk("reset.drop",  drop_a, 0);
        chk("reset.port",  bus_a.mac_dst_port_num, 0);
        chk("reset.for_us", bus_a.is_for_us, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_one("T1", 48'h0200_0000_0002, 16'h0800, 16'h0000, 16'h0000);
        chk("T1.lat_abs", 64'(obs_lat), 7);
        chk("T1.port_abs", obs_port, 3'b100);
        run_one("T2", 48'hFFFF_FFFF_FFFF, 16'h0806, 16'h0000, 16'h0000);
        chk("T2.lat_abs", 64'(obs_lat), 5);
        run_one("T3", 48'h0100_5E00_0001, 16'h0800, 16'h0000, 16'h0000);
        run_one("T4", 48'h0A0B_0C0D_0E0F, 16'h8100, 16'h2064, 16'h0800);
        chk("T4.lat_abs", 64'(obs_lat), 8);

        // Duplicate table entries: the lowest index must win.
        tbl[3] = tbl[1];
        apply_table();
        run_one("DUP", tbl[1], 16'h0800, 16'h0000, 16'h0000);
        tbl[3] = 48'h0200_0000_0003;
        apply_table();

        for (int p = 0; p < 40; p++) begin
            gen_pkt(dst, eo, tci, ei);
            run_one($sformatf("RND%0d", p), dst, eo, tci, ei);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Overflow: four results fill the result FIFO, four headers wait, two are dropped.
        for (int i = 0; i < 10; i++) begin
            gen_pkt(dst, eo, tci, ei);
            if (i < 8) begin
                qa.push_back(model(dst, eo, tci, ei, 1'b1));
                qb.push_back(model(dst, eo, tci, ei, 1'b0));
            end
            tdata = make_word(dst, eo, tci, ei);
            word  = 1'b1;
            @(negedge clk);
            word  = 1'b0;
            if (i < 4) repeat (11) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("T5.drop_a", drop_a, 2);
        chk("T5.drop_b", drop_b, 2);
        for (int i = 0; i < 8; i++) begin
            waited = 0;
            while (!bus_a.eth_parser_info_vld && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            check_heads($sformatf("T5.r%0d", i), qa[i], qb[i]);
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
        end
        repeat (20) @(negedge clk);
        chk("T5.empty", bus_a.eth_parser_info_vld, 0);
        chk("T5.drop_hold", drop_a, 2);

        // Reset while the first of three queued misses is being searched.
        for (int i = 0; i < 3; i++) begin
            tdata = make_word(48'h0600_0000_0010 | 48'(i), 16'h0800, 16'h0000, 16'h0000);
            word  = 1'b1;
            @(negedge clk);
        end
        word = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("T6.vld",  bus_a.eth_parser_info_vld, 0);
        chk("T6.drop", drop_a, 0);
        chk("T6.port", bus_a.mac_dst_port_num, 0);
        repeat (15) @(negedge clk);
        chk("T6.flushed", bus_a.eth_parser_info_vld, 0);
        run_one("T6.new", 48'h0200_0000_0001, 16'h0806, 16'h0000, 16'h0000);
        chk("T6.lat_abs", 64'(obs_lat), 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
